// File: rtl/pipeline_hazard_ctl_pkg.sv
// Shared encodings for the pipeline hazard controller:
// PC-select codes, result-source codes, FSM states, counter widths.
package pipeline_hazard_ctl_pkg;

  localparam int XLEN_32b = 32;
  localparam int XLEN_64b = 64;

  localparam logic [1:0] PC_SEL_PC4    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_MTVEC  = 2'b10;
  localparam logic [1:0] PC_SEL_MEPC   = 2'b11;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  localparam int DRAIN_W = 4;
  localparam int TMO_W   = 8;

  typedef enum logic [1:0] {
    S_RUN        = 2'b00,
    S_MC_WAIT    = 2'b01,
    S_TRAP_DRAIN = 2'b10
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctl_load_use_det.sv
// Load-use hazard compare: EX holds a load whose rd feeds rs1/rs2 in ID.
// In: rs1_d_i, rs2_d_i, rd_e_i, result_src_e_i, reg_wr_e_i. Out: hit_o.
module hazard_load_use_det
  import pipeline_hazard_ctl_pkg::*;
(
  input  logic [4:0] rs1_d_i,
  input  logic [4:0] rs2_d_i,
  input  logic [4:0] rd_e_i,
  input  logic [1:0] result_src_e_i,
  input  logic       reg_wr_e_i,
  output logic       hit_o
);

  logic is_load;
  logic rd_nz;
  logic match;

  assign is_load = (result_src_e_i == RESULT_SRC_LOAD);
  assign rd_nz   = (rd_e_i != 5'd0);
  assign match   = (rd_e_i == rs1_d_i) ||
                   (rd_e_i == rs2_d_i);
  assign hit_o   = is_load & reg_wr_e_i &
                   rd_nz & match;

endmodule

// File: rtl/pipeline_hazard_ctl.sv
// Hazard/sequencing controller: load-use, redirects, trap/mret, MC waits.
// In: ID/EX/MEM hazard info. Out: stage stall/enable/flush, pc_sel, strobes.
module pipeline_hazard_ctl
  import pipeline_hazard_ctl_pkg::*;
#(
  parameter int XLEN           = XLEN_64b,
  parameter int TRAP_DRAIN_CYC = 2,
  parameter int MC_TIMEOUT     = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_rs1_d,
  input  logic [4:0] i_rs2_d,
  input  logic [4:0] i_rd_e,
  input  logic [1:0] i_result_src_e,
  input  logic       i_reg_wr_e,
  input  logic       i_pc_src_e,
  input  logic       i_exception_m,
  input  logic       i_mret_m,
  input  logic       i_mc_start_e,
  input  logic       i_mc_done_e,
  output logic       o_stall_f,
  output logic       o_if_id_en,
  output logic       o_if_id_flush,
  output logic       o_id_ex_en,
  output logic       o_id_ex_flush,
  output logic       o_id_ex_flush_exception_m,
  output logic       o_ex_mem_flush,
  output logic [1:0] o_pc_sel,
  output logic       o_csr_trap_we,
  output logic       o_mc_timeout
);

  if (!(XLEN == XLEN_32b || XLEN == XLEN_64b)) begin : g_bad_xlen
    $error("pipeline_hazard_ctl: XLEN must be 32 or 64");
  end
  if (TRAP_DRAIN_CYC < 1 || TRAP_DRAIN_CYC > 15) begin : g_bad_drain
    $error("pipeline_hazard_ctl: TRAP_DRAIN_CYC out of 1..15");
  end
  if (MC_TIMEOUT < 2 || MC_TIMEOUT > 255) begin : g_bad_tmo
    $error("pipeline_hazard_ctl: MC_TIMEOUT out of 2..255");
  end

  localparam logic [DRAIN_W-1:0] DRAIN_INIT =
    DRAIN_W'(TRAP_DRAIN_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(MC_TIMEOUT - 1);

  hz_state_e          state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic lu_hit;
  logic trap_go;

  hazard_load_use_det u_lu (
    .rs1_d_i        (i_rs1_d),
    .rs2_d_i        (i_rs2_d),
    .rd_e_i         (i_rd_e),
    .result_src_e_i (i_result_src_e),
    .reg_wr_e_i     (i_reg_wr_e),
    .hit_o          (lu_hit)
  );

  // mret only redirects from RUN; in the other states MEM holds
  // bubbles, so only a fresh exception can preempt them.
  assign trap_go = i_exception_m |
                   (i_mret_m & (state_q == S_RUN));

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    tmo_d   = tmo_q;

    o_stall_f                 = 1'b0;
    o_if_id_en                = 1'b1;
    o_if_id_flush             = 1'b0;
    o_id_ex_en                = 1'b1;
    o_id_ex_flush             = 1'b0;
    o_id_ex_flush_exception_m = 1'b0;
    o_ex_mem_flush            = 1'b0;
    o_pc_sel                  = PC_SEL_PC4;
    o_csr_trap_we             = 1'b0;
    o_mc_timeout              = 1'b0;

    if (trap_go) begin
      o_if_id_flush             = 1'b1;
      o_id_ex_flush_exception_m = 1'b1;
      o_ex_mem_flush            = 1'b1;
      o_pc_sel      = i_exception_m ? PC_SEL_MTVEC
                                    : PC_SEL_MEPC;
      o_csr_trap_we = i_exception_m;
      drain_d = DRAIN_INIT;
      tmo_d   = '0;
      state_d = S_TRAP_DRAIN;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (i_pc_src_e) begin
            o_pc_sel      = PC_SEL_BRANCH;
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
          end else if (i_mc_start_e && !i_mc_done_e) begin
            o_stall_f      = 1'b1;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_flush = 1'b1;
            tmo_d   = '0;
            state_d = S_MC_WAIT;
          end else if (lu_hit) begin
            o_stall_f     = 1'b1;
            o_if_id_en    = 1'b0;
            o_id_ex_flush = 1'b1;
          end
        end
        S_MC_WAIT: begin
          if (i_mc_done_e) begin
            state_d = S_RUN;
          end else if (tmo_q == TMO_LAST) begin
            // Drop the stuck op from ID_EX and resume.
            o_mc_timeout  = 1'b1;
            o_id_ex_flush = 1'b1;
            state_d = S_RUN;
          end else begin
            o_stall_f      = 1'b1;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_flush = 1'b1;
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_TRAP_DRAIN: begin
          o_if_id_flush = 1'b1;
          drain_d = drain_q - 1'b1;
          if (drain_q <= 1) begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_RUN;
        end
      endcase
    end

    // Outputs fall to their idle values the moment reset asserts.
    if (!i_rst_n) begin
      o_stall_f                 = 1'b0;
      o_if_id_en                = 1'b1;
      o_if_id_flush             = 1'b0;
      o_id_ex_en                = 1'b1;
      o_id_ex_flush             = 1'b0;
      o_id_ex_flush_exception_m = 1'b0;
      o_ex_mem_flush            = 1'b0;
      o_pc_sel                  = PC_SEL_PC4;
      o_csr_trap_we             = 1'b0;
      o_mc_timeout              = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_RUN;
      drain_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// Directed bench for pipeline_hazard_ctl (default parameters).
// Inputs change #1 after posedge; outputs are checked on negedge.
module tb_pipeline_hazard_ctl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic [1:0] result_src_e;
  logic       reg_wr_e, pc_src_e;
  logic       exc_m, mret_m;
  logic       mc_start_e, mc_done_e;

  logic       stall_f, if_id_en, if_id_flush;
  logic       id_ex_en, id_ex_flush, id_ex_flush_x;
  logic       ex_mem_flush, trap_we, mc_tmo;
  logic [1:0] pc_sel;
  logic [10:0] obs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctl dut (
    .i_clk                     (clk),
    .i_rst_n                   (rst_n),
    .i_rs1_d                   (rs1_d),
    .i_rs2_d                   (rs2_d),
    .i_rd_e                    (rd_e),
    .i_result_src_e            (result_src_e),
    .i_reg_wr_e                (reg_wr_e),
    .i_pc_src_e                (pc_src_e),
    .i_exception_m             (exc_m),
    .i_mret_m                  (mret_m),
    .i_mc_start_e              (mc_start_e),
    .i_mc_done_e               (mc_done_e),
    .o_stall_f                 (stall_f),
    .o_if_id_en                (if_id_en),
    .o_if_id_flush             (if_id_flush),
    .o_id_ex_en                (id_ex_en),
    .o_id_ex_flush             (id_ex_flush),
    .o_id_ex_flush_exception_m (id_ex_flush_x),
    .o_ex_mem_flush            (ex_mem_flush),
    .o_pc_sel                  (pc_sel),
    .o_csr_trap_we             (trap_we),
    .o_mc_timeout              (mc_tmo)
  );

  assign obs = {stall_f, if_id_en, if_id_flush,
                id_ex_en, id_ex_flush, id_ex_flush_x,
                ex_mem_flush, pc_sel, trap_we, mc_tmo};

  function automatic logic [10:0] ex(
    input logic s, ie, ifl, ee, efl, efx, mfl,
    input logic [1:0] sel,
    input logic twe, tmo);
    return {s, ie, ifl, ee, efl, efx, mfl, sel, twe, tmo};
  endfunction

  logic [10:0] IDLE, LU, BR, HOLD, TMO, EXC, MRET, DRN;

  task automatic chk(input string tag, input logic [10:0] e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  task automatic cyc(input string tag, input logic [10:0] e);
    @(negedge clk);
    chk(tag, e);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1_d = 5'd0; rs2_d = 5'd0; rd_e = 5'd0;
    result_src_e = 2'b00; reg_wr_e = 1'b0;
    pc_src_e = 1'b0; exc_m = 1'b0; mret_m = 1'b0;
    mc_start_e = 1'b0; mc_done_e = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd,
                        input logic [4:0] r1,
                        input logic [4:0] r2);
    rd_e = rd; rs1_d = r1; rs2_d = r2;
    result_src_e = 2'b01; reg_wr_e = 1'b1;
  endtask

  initial begin
    //   stall ifen iffl exen exfl exfx mfl sel twe tmo
    IDLE = ex(0, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0);
    LU   = ex(1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0);
    BR   = ex(0, 1, 1, 1, 1, 0, 0, 2'b01, 0, 0);
    HOLD = ex(1, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0);
    TMO  = ex(0, 1, 0, 1, 1, 0, 0, 2'b00, 0, 1);
    EXC  = ex(0, 1, 1, 1, 0, 1, 1, 2'b10, 1, 0);
    MRET = ex(0, 1, 1, 1, 0, 1, 1, 2'b11, 0, 0);
    DRN  = ex(0, 1, 1, 1, 0, 0, 0, 2'b00, 0, 0);

    // Reset: outputs idle even with an exception pending.
    clr();
    rst_n = 1'b0;
    exc_m = 1'b1;
    cyc("reset_a", IDLE);
    cyc("reset_b", IDLE);
    rst_n = 1'b1;
    clr();
    cyc("run_idle", IDLE);

    // Load-use on rs2: one bubble, then clear.
    set_lu(5'd5, 5'd1, 5'd5);
    cyc("lu_rs2", LU);
    clr();
    cyc("lu_after", IDLE);
    set_lu(5'd7, 5'd7, 5'd2);
    cyc("lu_rs1", LU);
    set_lu(5'd0, 5'd0, 5'd0);
    cyc("lu_rd0", IDLE);
    set_lu(5'd5, 5'd1, 5'd5);
    reg_wr_e = 1'b0;
    cyc("lu_nowr", IDLE);
    set_lu(5'd5, 5'd1, 5'd5);
    result_src_e = 2'b00;
    cyc("lu_noload", IDLE);

    // Branch beats load-use.
    set_lu(5'd5, 5'd1, 5'd5);
    pc_src_e = 1'b1;
    cyc("br_lu", BR);
    clr();
    cyc("br_after", IDLE);

    // Multi-cycle: 5 held cycles, released on done.
    mc_start_e = 1'b1;
    cyc("mc_start", HOLD);
    mc_start_e = 1'b0;
    for (int i = 0; i < 4; i++) cyc("mc_hold", HOLD);
    mc_done_e = 1'b1;
    cyc("mc_done", IDLE);
    clr();
    cyc("mc_after", IDLE);

    // Start with done already high: no wait entered.
    mc_start_e = 1'b1;
    mc_done_e  = 1'b1;
    cyc("mc_fast", IDLE);
    clr();
    cyc("mc_fast_after", IDLE);

    // Timeout: pulse on the 64th wait-state cycle.
    mc_start_e = 1'b1;
    cyc("tmo_start", HOLD);
    mc_start_e = 1'b0;
    for (int i = 0; i < 63; i++) cyc("tmo_hold", HOLD);
    cyc("tmo_pulse", TMO);
    cyc("tmo_after", IDLE);

    // Exception: strobe, then 2 drain cycles.
    exc_m = 1'b1;
    cyc("exc", EXC);
    clr();
    cyc("exc_drn1", DRN);
    cyc("exc_drn2", DRN);
    cyc("exc_after", IDLE);

    // mret: mepc, no strobe.
    mret_m = 1'b1;
    cyc("mret", MRET);
    clr();
    cyc("mret_drn1", DRN);
    cyc("mret_drn2", DRN);
    cyc("mret_after", IDLE);

    // Both: exception wins.
    exc_m  = 1'b1;
    mret_m = 1'b1;
    cyc("both", EXC);
    clr();
    cyc("both_drn1", DRN);
    cyc("both_drn2", DRN);
    cyc("both_after", IDLE);

    // Exception aborts a multi-cycle wait.
    mc_start_e = 1'b1;
    cyc("mcx_start", HOLD);
    mc_start_e = 1'b0;
    cyc("mcx_hold1", HOLD);
    cyc("mcx_hold2", HOLD);
    exc_m = 1'b1;
    cyc("mcx_exc", EXC);
    clr();
    cyc("mcx_drn1", DRN);
    cyc("mcx_drn2", DRN);
    cyc("mcx_after", IDLE);

    // Drain ignores branch/load-use; new exception restarts.
    exc_m = 1'b1;
    cyc("rx_exc", EXC);
    clr();
    set_lu(5'd5, 5'd5, 5'd0);
    pc_src_e = 1'b1;
    cyc("rx_drn_ign", DRN);
    clr();
    exc_m = 1'b1;
    cyc("rx_exc2", EXC);
    clr();
    cyc("rx_drn1", DRN);
    cyc("rx_drn2", DRN);
    cyc("rx_after", IDLE);

    // Reset in the middle of drain.
    exc_m = 1'b1;
    cyc("rd_exc", EXC);
    clr();
    cyc("rd_drn1", DRN);
    rst_n = 1'b0;
    #1;
    chk("rst_async", IDLE);
    @(negedge clk);
    chk("rst_hold", IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("rst_rel1", IDLE);
    cyc("rst_rel2", IDLE);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
